// File: rtl/starflux_pkg.sv
// ---------------------------------------------------------------------------
// starflux_pkg
// Shared constants for the starflux playfield: screen geometry, coordinate
// widths and default timing for the enemy projectile scheduler, plus a small
// ring-index helper used by the round-robin arbiter.
// ---------------------------------------------------------------------------
package starflux_pkg;

  localparam int SCREEN_W           = 160;
  localparam int SCREEN_H           = 120;
  localparam int X_W                = 8;
  localparam int Y_W                = 7;
  localparam int DEFAULT_TICK_COUNT = 2499999;  // 20 Hz movement at 50 MHz
  localparam int DEFAULT_Y_START    = 8;
  localparam int DEFAULT_Y_LIMIT    = SCREEN_H - 1;
  localparam int DEFAULT_STEP       = 1;

  // Index following idx on a ring of n entries.
  function automatic int ring_next(input int idx, input int n);
    if (idx + 1 >= n) begin
      return 0;
    end else begin
      return idx + 1;
    end
  endfunction

  // Index k positions after base on a ring of n entries (k < n).
  function automatic int ring_add(input int base, input int k, input int n);
    if (base + k >= n) begin
      return base + k - n;
    end else begin
      return base + k;
    end
  endfunction

endpackage

// File: rtl/enemy_shot_scheduler_tick_gen.sv
// ---------------------------------------------------------------------------
// shot_tick_gen
// Movement tick generator. A down-counter starts at TICK_COUNT, and when it
// reaches zero it reloads and raises tick for exactly one clock, giving one
// pulse every TICK_COUNT+1 clocks.
//   clock  in   system clock
//   resetn in   asynchronous active-low reset
//   tick   out  registered one-clock movement pulse
// ---------------------------------------------------------------------------
module shot_tick_gen
  import starflux_pkg::*;
#(
  parameter int TICK_COUNT = DEFAULT_TICK_COUNT
) (
  input  logic clock,
  input  logic resetn,
  output logic tick
);

  localparam int              CNT_W  = (TICK_COUNT > 0) ? $clog2(TICK_COUNT + 1) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TICK_COUNT);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  logic [CNT_W-1:0] count_r;
  logic             tick_r;

  // Countdown with reload; the pulse lands in the clock after the zero count.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count_r <= RELOAD;
      tick_r  <= 1'b0;
    end else if (count_r == {CNT_W{1'b0}}) begin
      count_r <= RELOAD;
      tick_r  <= 1'b1;
    end else begin
      count_r <= count_r - ONE;
      tick_r  <= 1'b0;
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/enemy_shot_scheduler.sv
// ---------------------------------------------------------------------------
// enemy_shot_scheduler
// Arbitrates enemy fire requests round-robin into a fixed pool of bullet
// slots, moves live bullets down the playfield on each movement tick and
// retires bullets that pass the last visible row or are killed.
//   clock        in   system clock
//   resetn       in   asynchronous active-low reset
//   fire_req     in   level fire request per enemy, held until granted
//   fire_x       in   x of requester i at [8i+7:8i], sampled on grant
//   kill         in   per-slot clear from collision logic
//   fire_grant   out  registered one-hot grant pulse
//   slot_active  out  slot holds a live bullet
//   slot_x       out  x per slot, [8s+7:8s]
//   slot_y       out  y per slot, [7s+6:7s]
//   tick         out  registered movement pulse
// Per-slot priority each clock: kill, then allocation, then advance.
// ---------------------------------------------------------------------------
module enemy_shot_scheduler
  import starflux_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int NUM_SLOTS  = 4,
  parameter int TICK_COUNT = DEFAULT_TICK_COUNT,
  parameter int Y_START    = DEFAULT_Y_START,
  parameter int Y_LIMIT    = DEFAULT_Y_LIMIT,
  parameter int STEP       = DEFAULT_STEP
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic [NUM_REQ-1:0]         fire_req,
  input  logic [X_W*NUM_REQ-1:0]     fire_x,
  input  logic [NUM_SLOTS-1:0]       kill,
  output logic [NUM_REQ-1:0]         fire_grant,
  output logic [NUM_SLOTS-1:0]       slot_active,
  output logic [X_W*NUM_SLOTS-1:0]   slot_x,
  output logic [Y_W*NUM_SLOTS-1:0]   slot_y,
  output logic                       tick
);

  localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int SUM_W  = Y_W + 1;  // one spare bit so y+STEP never wraps

  localparam logic [Y_W-1:0]   Y_START_V = Y_W'(Y_START);
  localparam logic [SUM_W-1:0] STEP_V    = SUM_W'(STEP);
  localparam logic [SUM_W-1:0] LIMIT_V   = SUM_W'(Y_LIMIT);

  logic                      tick_s;
  logic [PTR_W-1:0]          ptr_r;
  logic [NUM_REQ-1:0]        grant_r;
  logic [NUM_SLOTS-1:0]      active_r;
  logic [X_W*NUM_SLOTS-1:0]  x_r;
  logic [Y_W*NUM_SLOTS-1:0]  y_r;

  logic                      free_found_s;
  logic [SLOT_W-1:0]         free_idx_s;
  logic                      req_found_s;
  logic [PTR_W-1:0]          req_idx_s;
  logic                      grant_s;
  logic [SUM_W-1:0]          sum_s;

  logic [PTR_W-1:0]          ptr_n_s;
  logic [NUM_REQ-1:0]        grant_n_s;
  logic [NUM_SLOTS-1:0]      active_n_s;
  logic [X_W*NUM_SLOTS-1:0]  x_n_s;
  logic [Y_W*NUM_SLOTS-1:0]  y_n_s;

  shot_tick_gen #(
    .TICK_COUNT (TICK_COUNT)
  ) u_tick_gen (
    .clock  (clock),
    .resetn (resetn),
    .tick   (tick_s)
  );

  // Lowest free slot: idle at the start of the cycle and not being killed now.
  always_comb begin
    free_found_s = 1'b0;
    free_idx_s   = {SLOT_W{1'b0}};
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (!free_found_s && !active_r[s] && !kill[s]) begin
        free_found_s = 1'b1;
        free_idx_s   = SLOT_W'(s);
      end else begin
        free_found_s = free_found_s;
      end
    end
  end

  // Round-robin search for the first requester at or after the pointer.
  always_comb begin
    req_found_s = 1'b0;
    req_idx_s   = {PTR_W{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!req_found_s && fire_req[ring_add(int'(ptr_r), k, NUM_REQ)]) begin
        req_found_s = 1'b1;
        req_idx_s   = PTR_W'(ring_add(int'(ptr_r), k, NUM_REQ));
      end else begin
        req_found_s = req_found_s;
      end
    end
  end

  assign grant_s = req_found_s && free_found_s;

  // Next grant, pointer and slot state with kill > allocation > advance.
  always_comb begin
    ptr_n_s    = ptr_r;
    grant_n_s  = {NUM_REQ{1'b0}};
    active_n_s = active_r;
    x_n_s      = x_r;
    y_n_s      = y_r;
    sum_s      = {SUM_W{1'b0}};
    if (grant_s) begin
      grant_n_s[req_idx_s] = 1'b1;
      ptr_n_s              = PTR_W'(ring_next(int'(req_idx_s), NUM_REQ));
    end else begin
      ptr_n_s = ptr_r;
    end
    for (int s = 0; s < NUM_SLOTS; s++) begin
      sum_s = {1'b0, y_r[s*Y_W +: Y_W]} + STEP_V;
      if (kill[s]) begin
        active_n_s[s] = 1'b0;
      end else if (grant_s && (free_idx_s == SLOT_W'(s))) begin
        active_n_s[s]           = 1'b1;
        x_n_s[s*X_W +: X_W]     = fire_x[req_idx_s*X_W +: X_W];
        y_n_s[s*Y_W +: Y_W]     = Y_START_V;
      end else if (tick_s && active_r[s]) begin
        // Past the last row the bullet retires and y keeps its final value.
        if (sum_s > LIMIT_V) begin
          active_n_s[s] = 1'b0;
        end else begin
          y_n_s[s*Y_W +: Y_W] = sum_s[Y_W-1:0];
        end
      end else begin
        active_n_s[s] = active_r[s];
      end
    end
  end

  // Arbiter and slot state registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ptr_r    <= {PTR_W{1'b0}};
      grant_r  <= {NUM_REQ{1'b0}};
      active_r <= {NUM_SLOTS{1'b0}};
      x_r      <= {(X_W*NUM_SLOTS){1'b0}};
      y_r      <= {(Y_W*NUM_SLOTS){1'b0}};
    end else begin
      ptr_r    <= ptr_n_s;
      grant_r  <= grant_n_s;
      active_r <= active_n_s;
      x_r      <= x_n_s;
      y_r      <= y_n_s;
    end
  end

  assign fire_grant  = grant_r;
  assign slot_active = active_r;
  assign slot_x      = x_r;
  assign slot_y      = y_r;
  assign tick        = tick_s;

endmodule

// File: tb/tb_enemy_shot_scheduler.sv
// ---------------------------------------------------------------------------
// tb_enemy_shot_scheduler
// Directed bench for enemy_shot_scheduler with TICK_COUNT=3 (tick every four
// clocks). The main instance uses Y_START=8; a second instance with
// Y_START=117 covers bullet retirement at the bottom of the screen.
// ---------------------------------------------------------------------------
module tb_enemy_shot_scheduler;

  logic        clock;
  logic        resetn;

  logic [3:0]  fire_req;
  logic [31:0] fire_x;
  logic [3:0]  kill;
  logic [3:0]  fire_grant;
  logic [3:0]  slot_active;
  logic [31:0] slot_x;
  logic [27:0] slot_y;
  logic        tick;

  logic [3:0]  r_fire_req;
  logic [31:0] r_fire_x;
  logic [3:0]  r_kill;
  logic [3:0]  r_fire_grant;
  logic [3:0]  r_slot_active;
  logic [31:0] r_slot_x;
  logic [27:0] r_slot_y;
  logic        r_tick;

  int checks;
  int errors;

  enemy_shot_scheduler #(
    .NUM_REQ(4), .NUM_SLOTS(4), .TICK_COUNT(3),
    .Y_START(8), .Y_LIMIT(119), .STEP(1)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .fire_req    (fire_req),
    .fire_x      (fire_x),
    .kill        (kill),
    .fire_grant  (fire_grant),
    .slot_active (slot_active),
    .slot_x      (slot_x),
    .slot_y      (slot_y),
    .tick        (tick)
  );

  enemy_shot_scheduler #(
    .NUM_REQ(4), .NUM_SLOTS(4), .TICK_COUNT(3),
    .Y_START(117), .Y_LIMIT(119), .STEP(1)
  ) dut_r (
    .clock       (clock),
    .resetn      (resetn),
    .fire_req    (r_fire_req),
    .fire_x      (r_fire_x),
    .kill        (r_kill),
    .fire_grant  (r_fire_grant),
    .slot_active (r_slot_active),
    .slot_x      (r_slot_x),
    .slot_y      (r_slot_y),
    .tick        (r_tick)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  function automatic logic [31:0] y_of(input logic [27:0] v, input int s);
    return {25'd0, v[7*s +: 7]};
  endfunction

  function automatic logic [31:0] x_of(input logic [31:0] v, input int s);
    return {24'd0, v[8*s +: 8]};
  endfunction

  task automatic step_clk();
    @(posedge clock);
    #1;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    resetn     = 1'b0;
    fire_req   = 4'd0;
    fire_x     = 32'd0;
    kill       = 4'd0;
    r_fire_req = 4'd0;
    r_fire_x   = 32'd0;
    r_kill     = 4'd0;

    repeat (2) @(posedge clock);
    #1;
    check_value("rst_grant",  {28'd0, fire_grant},  32'd0);
    check_value("rst_active", {28'd0, slot_active}, 32'd0);
    check_value("rst_x",      slot_x,               32'd0);
    check_value("rst_y",      {4'd0, slot_y},       32'd0);
    check_value("rst_tick",   {31'd0, tick},        32'd0);

    // Single request from enemy 0.
    fire_req = 4'b0001;
    fire_x   = 32'd42;
    resetn   = 1'b1;
    step_clk();  // e1
    check_value("single_grant",  {28'd0, fire_grant},  32'd1);
    check_value("single_active", {28'd0, slot_active}, 32'd1);
    check_value("single_x0",     x_of(slot_x, 0),      32'd42);
    check_value("single_y0",     y_of(slot_y, 0),      32'd8);
    check_value("tick_e1",       {31'd0, tick},        32'd0);
    fire_req = 4'b0000;
    step_clk();  // e2
    check_value("grant_pulse",   {28'd0, fire_grant},  32'd0);
    check_value("active_hold",   {28'd0, slot_active}, 32'd1);
    step_clk();  // e3
    check_value("tick_e3",       {31'd0, tick},        32'd0);
    step_clk();  // e4
    check_value("tick_e4",       {31'd0, tick},        32'd1);
    check_value("y0_e4",         y_of(slot_y, 0),      32'd8);
    step_clk();  // e5
    check_value("tick_e5",       {31'd0, tick},        32'd0);
    check_value("y0_e5",         y_of(slot_y, 0),      32'd9);
    repeat (3) step_clk();  // e8
    check_value("tick_e8",       {31'd0, tick},        32'd1);
    step_clk();  // e9
    check_value("y0_e9",         y_of(slot_y, 0),      32'd10);

    // Asynchronous reset between edges with a bullet live.
    #2;
    resetn = 1'b0;
    #1;
    check_value("arst_active", {28'd0, slot_active}, 32'd0);
    check_value("arst_grant",  {28'd0, fire_grant},  32'd0);
    check_value("arst_x",      slot_x,               32'd0);
    check_value("arst_y",      {4'd0, slot_y},       32'd0);
    check_value("arst_tick",   {31'd0, tick},        32'd0);
    step_clk();

    // Round-robin with all four enemies requesting; retire instance fires too.
    fire_req   = 4'b1111;
    fire_x     = {8'd103, 8'd102, 8'd101, 8'd100};
    r_fire_req = 4'b0001;
    r_fire_x   = 32'd7;
    resetn     = 1'b1;
    step_clk();  // E1
    check_value("rr_grant0",  {28'd0, fire_grant},  32'b0001);
    check_value("rr_active0", {28'd0, slot_active}, 32'b0001);
    check_value("rr_x0",      x_of(slot_x, 0),      32'd100);
    check_value("rr_tick_E1", {31'd0, tick},        32'd0);
    check_value("ret_y_E1",   y_of(r_slot_y, 0),    32'd117);
    r_fire_req = 4'b0000;
    step_clk();  // E2
    check_value("rr_grant1",  {28'd0, fire_grant},  32'b0010);
    check_value("rr_active1", {28'd0, slot_active}, 32'b0011);
    check_value("rr_x1",      x_of(slot_x, 1),      32'd101);
    step_clk();  // E3
    check_value("rr_grant2",  {28'd0, fire_grant},  32'b0100);
    check_value("rr_tick_E3", {31'd0, tick},        32'd0);
    step_clk();  // E4
    check_value("rr_grant3",  {28'd0, fire_grant},  32'b1000);
    check_value("rr_active3", {28'd0, slot_active}, 32'b1111);
    check_value("rr_x3",      x_of(slot_x, 3),      32'd103);
    check_value("rr_tick_E4", {31'd0, tick},        32'd1);
    check_value("rr_y_E4",    {4'd0, slot_y},       {4'd0, 7'd8, 7'd8, 7'd8, 7'd8});
    step_clk();  // E5
    check_value("full_grant_E5", {28'd0, fire_grant}, 32'd0);
    check_value("adv_y_E5",   {4'd0, slot_y},       {4'd0, 7'd9, 7'd9, 7'd9, 7'd9});
    check_value("ret_y_E5",   y_of(r_slot_y, 0),    32'd118);
    step_clk();  // E6
    check_value("full_grant_E6", {28'd0, fire_grant}, 32'd0);

    // Pool full: kill slot 2 while enemy 2 requests.
    fire_req = 4'b0100;
    kill     = 4'b0100;
    step_clk();  // E7
    check_value("kill_active", {28'd0, slot_active}, 32'b1011);
    check_value("kill_nogrant", {28'd0, fire_grant}, 32'd0);
    kill = 4'b0000;
    step_clk();  // E8
    check_value("refill_grant",  {28'd0, fire_grant},  32'b0100);
    check_value("refill_active", {28'd0, slot_active}, 32'b1111);
    check_value("refill_x2",     x_of(slot_x, 2),      32'd102);
    check_value("refill_y2",     y_of(slot_y, 2),      32'd8);
    check_value("tick_E8",       {31'd0, tick},        32'd1);
    fire_req = 4'b0000;
    step_clk();  // E9
    check_value("adv_y_E9",  {4'd0, slot_y}, {4'd0, 7'd10, 7'd9, 7'd10, 7'd10});
    check_value("ret_y_E9",  y_of(r_slot_y, 0), 32'd119);
    check_value("ret_act_E9", {28'd0, r_slot_active}, 32'd1);

    // Free slot 1 so the next allocation lands there.
    kill = 4'b0010;
    step_clk();  // E10
    check_value("kill1_active", {28'd0, slot_active}, 32'b1101);
    kill = 4'b0000;
    step_clk();  // E11
    step_clk();  // E12
    check_value("tick_E12", {31'd0, tick}, 32'd1);

    // Tick, allocation into slot 1 and kill of slot 0 on the same edge.
    kill     = 4'b0001;
    fire_req = 4'b0001;
    fire_x   = {8'd103, 8'd102, 8'd101, 8'd55};
    step_clk();  // E13
    check_value("sim_grant",  {28'd0, fire_grant},  32'b0001);
    check_value("sim_active", {28'd0, slot_active}, 32'b1110);
    check_value("sim_x1",     x_of(slot_x, 1),      32'd55);
    check_value("sim_x2",     x_of(slot_x, 2),      32'd102);
    check_value("sim_y0",     y_of(slot_y, 0),      32'd10);
    check_value("sim_y1",     y_of(slot_y, 1),      32'd8);
    check_value("sim_y2",     y_of(slot_y, 2),      32'd10);
    check_value("sim_y3",     y_of(slot_y, 3),      32'd11);
    check_value("ret_act_E13", {28'd0, r_slot_active}, 32'd0);
    check_value("ret_y_E13",   y_of(r_slot_y, 0),     32'd119);
    fire_req = 4'b0000;
    kill     = 4'b0000;
    step_clk();  // E14
    check_value("end_grant", {28'd0, fire_grant}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
